writeback_queue: RTL and testbench

//  Write-back buffer directly upstream of the register file write port (we/rZ_address/rZ).

---
 rtl/writeback_queue.sv | 142 ++++++++++++++
 tb/tb_writeback_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back buffer in front of the single register
// file write port. Load and ALU results arrive over valid/ready handshakes.
// When both arrive in the same cycle, the load result is the older entry.
// Exactly one entry retires per cycle whenever the queue is non-empty.
// Optional feature macro: WBQ_BYPASS_EN adds a combinational youngest-match
// forwarding lookup over the stored entries.
module writeback_queue #(
  parameter int dtype    = 16,
  parameter int nregs    = 8,
  parameter int addr_len = $clog2(nregs),
  parameter int depth    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [addr_len-1:0]        mem_addr,
  input  logic [dtype-1:0]           mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [addr_len-1:0]        alu_addr,
  input  logic [dtype-1:0]           alu_data,
`ifdef WBQ_BYPASS_EN
  input  logic [addr_len-1:0]        rX_address,
  input  logic [addr_len-1:0]        rY_address,
  output logic                       fwd_x_hit,
  output logic                       fwd_y_hit,
  output logic [dtype-1:0]           fwd_x,
  output logic [dtype-1:0]           fwd_y,
`endif
  output logic                       we,
  output logic [addr_len-1:0]        rZ_address,
  output logic [dtype-1:0]           rZ,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  logic [addr_len-1:0] addr_q [depth];
  logic [dtype-1:0]    data_q [depth];
  logic [ptr_w-1:0]    wr_ptr;
  logic [ptr_w-1:0]    rd_ptr;
  logic [cnt_w-1:0]    count_q;

  logic [cnt_w-1:0]    free_slots;
  logic                mem_push;
  logic                alu_push;
  logic                pop;
  logic [cnt_w-1:0]    push_cnt;
  logic [ptr_w-1:0]    alu_slot;

  // Readiness looks only at the registered occupancy; the slot freed by this
  // cycle's retirement is deliberately not credited. The ALU side reserves
  // room for a load that is offered in the same cycle.
  assign free_slots = cnt_w'(depth) - count_q;
  assign mem_ready  = (free_slots != '0);
  assign alu_ready  = mem_valid ? (free_slots >= cnt_w'(2)) : (free_slots != '0);

  // Register 0 results complete their handshake but are never stored.
  assign mem_push = mem_valid && mem_ready && (mem_addr != '0);
  assign alu_push = alu_valid && alu_ready && (alu_addr != '0);
  assign pop      = (count_q != '0);
  assign push_cnt = cnt_w'(mem_push) + cnt_w'(alu_push);
  assign alu_slot = wr_ptr + ptr_w'(mem_push);

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo depth.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + ptr_w'(push_cnt);
      rd_ptr  <= rd_ptr + ptr_w'(pop);
      count_q <= count_q + push_cnt - cnt_w'(pop);
    end
  end

  // Entry storage: the load result takes the first free slot, the ALU result the next.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (mem_push) begin
        addr_q[wr_ptr] <= mem_addr;
        data_q[wr_ptr] <= mem_data;
      end
      if (alu_push) begin
        addr_q[alu_slot] <= alu_addr;
        data_q[alu_slot] <= alu_data;
      end
    end
  end

  // The retire port is driven only from storage; it is zeroed while the queue is empty.
  always_comb begin
    we         = pop;
    rZ_address = '0;
    rZ         = '0;
    if (pop) begin
      rZ_address = addr_q[rd_ptr];
      rZ         = data_q[rd_ptr];
    end
  end

  assign count = count_q;
  assign full  = (count_q == cnt_w'(depth));
  assign empty = (count_q == '0);

`ifdef WBQ_BYPASS_EN
  // Walk occupied entries from oldest to youngest so the last match wins;
  // the head still counts even though it retires this cycle.
  always_comb begin
    logic [ptr_w-1:0] slot;
    fwd_x_hit = 1'b0;
    fwd_y_hit = 1'b0;
    fwd_x     = '0;
    fwd_y     = '0;
    slot      = '0;
    for (int i = 0; i < depth; i++) begin
      slot = rd_ptr + ptr_w'(i);
      if (cnt_w'(i) < count_q) begin
        if ((rX_address != '0) && (addr_q[slot] == rX_address)) begin
          fwd_x_hit = 1'b1;
          fwd_x     = data_q[slot];
        end
        if ((rY_address != '0) && (addr_q[slot] == rY_address)) begin
          fwd_y_hit = 1'b1;
          fwd_y     = data_q[slot];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and short random traffic against a queue-based
// reference model of the write-back buffer, plus literal spot checks.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [2:0]  mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [2:0]  alu_addr = '0;
  logic [15:0] alu_data = '0;
  logic        we;
  logic [2:0]  rZ_address;
  logic [15:0] rZ;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef WBQ_BYPASS_EN
  logic [2:0]  rX_address = '0;
  logic [2:0]  rY_address = '0;
  logic        fwd_x_hit;
  logic        fwd_y_hit;
  logic [15:0] fwd_x;
  logic [15:0] fwd_y;
`endif

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } entry_t;

  entry_t      model_q[$];
  logic [15:0] log_d[$];
  logic [2:0]  log_a[$];
  int num_compared   = 0;
  int num_mismatched = 0;
  int zero_writes    = 0;
  int max_count      = 0;

  writeback_queue dut (
    .clock(clock), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
`ifdef WBQ_BYPASS_EN
    .rX_address(rX_address), .rY_address(rY_address),
    .fwd_x_hit(fwd_x_hit), .fwd_y_hit(fwd_y_hit), .fwd_x(fwd_x), .fwd_y(fwd_y),
`endif
    .we(we), .rZ_address(rZ_address), .rZ(rZ),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    num_compared++;
    if (actual != expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit exp_mem_ready();
    return (DEPTH - model_q.size()) >= 1;
  endfunction

  function automatic bit exp_alu_ready();
    return (DEPTH - model_q.size()) >= (1 + int'(mem_valid));
  endfunction

  // Youngest stored entry for a register, searched at the queue level.
  function automatic int model_lookup(input logic [2:0] addr, output bit hit);
    int data = 0;
    hit = 1'b0;
    if (addr != 0)
      foreach (model_q[i])
        if (model_q[i].a == addr) begin
          hit  = 1'b1;
          data = int'(model_q[i].d);
        end
    return data;
  endfunction

  // Reference model: head retires each edge it exists, then accepted non-r0 results append, load first.
  always @(posedge clock or negedge reset) begin
    bit mf, af;
    if (!reset) begin
      model_q.delete();
    end else begin
      mf = mem_valid && exp_mem_ready();
      af = alu_valid && exp_alu_ready();
      if (model_q.size() > 0) void'(model_q.pop_front());
      if (mf && mem_addr != 0) model_q.push_back({mem_addr, mem_data});
      if (af && alu_addr != 0) model_q.push_back({alu_addr, alu_data});
    end
  end

  // Compare every output against the model mid-cycle and log the retire stream.
  always @(negedge clock) begin
    bit hit;
    int data;
    checkOutput("we", we, model_q.size() > 0);
    checkOutput("rZ_address", rZ_address, model_q.size() > 0 ? int'(model_q[0].a) : 0);
    checkOutput("rZ", rZ, model_q.size() > 0 ? int'(model_q[0].d) : 0);
    checkOutput("count", count, model_q.size());
    checkOutput("full", full, model_q.size() == DEPTH);
    checkOutput("empty", empty, model_q.size() == 0);
    checkOutput("mem_ready", mem_ready, exp_mem_ready());
    checkOutput("alu_ready", alu_ready, exp_alu_ready());
`ifdef WBQ_BYPASS_EN
    data = model_lookup(rX_address, hit);
    checkOutput("fwd_x_hit", fwd_x_hit, hit);
    checkOutput("fwd_x", fwd_x, data);
    data = model_lookup(rY_address, hit);
    checkOutput("fwd_y_hit", fwd_y_hit, hit);
    checkOutput("fwd_y", fwd_y, data);
`else
    data = model_lookup(3'd0, hit);
`endif
    if (we) begin
      log_d.push_back(rZ);
      log_a.push_back(rZ_address);
      if (rZ_address == 0) zero_writes++;
    end
    if (int'(count) > max_count) max_count = int'(count);
  end

  task automatic setInputs(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                           input logic av, input logic [2:0] aa, input logic [15:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  task automatic applyStimulus(input logic mv, input logic [2:0] ma, input logic [15:0] md,
                               input logic av, input logic [2:0] aa, input logic [15:0] ad);
    setInputs(mv, ma, md, av, aa, ad);
    @(posedge clock);
    #1;
    setInputs(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic idle(input int n);
    setInputs(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    num_mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

  initial begin
    int guard;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    idle(2);

    // Reset mid-traffic: three entries in flight are discarded
    $display("[TB] reset mid-traffic");
    log_d.delete(); log_a.delete();
    applyStimulus(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022);
    applyStimulus(1'b1, 3'd3, 16'h0033, 1'b1, 3'd4, 16'h0044);
    checkOutput("pre_reset_count", count, 3);
    reset = 1'b0;
    #1;
    checkOutput("rst_we", we, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_rZ", rZ, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(4);
    checkOutput("rst_retired_count", log_d.size(), 1);
    if (log_d.size() > 0) checkOutput("rst_retired_first", log_d[0], 16'h0011);

    // Dual push into empty queue: load retires first, ALU next
    $display("[TB] dual push");
    log_d.delete(); log_a.delete();
    applyStimulus(1'b1, 3'd2, 16'h1111, 1'b1, 3'd2, 16'h2222);
    checkOutput("dual_we0", we, 1);
    checkOutput("dual_addr0", rZ_address, 2);
    checkOutput("dual_data0", rZ, 16'h1111);
    idle(1);
    checkOutput("dual_we1", we, 1);
    checkOutput("dual_data1", rZ, 16'h2222);
    idle(2);
    checkOutput("dual_log_size", log_d.size(), 2);

    // Back-pressure at three occupied entries
    $display("[TB] back-pressure");
    applyStimulus(1'b1, 3'd1, 16'h00A1, 1'b1, 3'd2, 16'h00A2);
    applyStimulus(1'b1, 3'd3, 16'h00A3, 1'b1, 3'd4, 16'h00A4);
    setInputs(1'b1, 3'd5, 16'h00A5, 1'b1, 3'd6, 16'h00A6);
    #1;
    checkOutput("bp_count", count, 3);
    checkOutput("bp_mem_ready", mem_ready, 1);
    checkOutput("bp_alu_ready", alu_ready, 0);
    checkOutput("bp_full", full, 0);
    @(posedge clock);
    #1;
    setInputs(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h00A7);
    #1;
    checkOutput("bp_alu_ready_alone", alu_ready, 1);
    @(posedge clock);
    #1;
    idle(6);
    checkOutput("bp_drained", empty, 1);

    // Register-0 discard
    $display("[TB] register 0 discard");
    setInputs(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hBEEF);
    #1;
    checkOutput("r0_alu_ready", alu_ready, 1);
    @(posedge clock);
    #1;
    setInputs(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    checkOutput("r0_count", count, 0);
    checkOutput("r0_we", we, 0);
    idle(2);

    // Wrap-around: twelve ALU results with random gaps
    $display("[TB] wrap-around stream");
    log_d.delete(); log_a.delete();
    for (int k = 1; k <= 12; k++) begin
      idle($urandom_range(0, 2));
      setInputs(1'b0, 3'd0, 16'h0, 1'b1, 3'(((k - 1) % 7) + 1), 16'(k));
      #1;
      guard = 0;
      while (!alu_ready && guard < 20) begin
        @(posedge clock);
        #1;
        guard++;
      end
      if (guard >= 20) checkOutput("wrap_accept_timeout", guard, 0);
      @(posedge clock);
      #1;
      setInputs(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    end
    idle(4);
    checkOutput("wrap_log_size", log_d.size(), 12);
    for (int i = 0; i < 12 && i < log_d.size(); i++)
      checkOutput("wrap_data", log_d[i], i + 1);

    // Random mixed traffic including register 0
    $display("[TB] random mixed traffic");
    for (int i = 0; i < 60; i++) begin
`ifdef WBQ_BYPASS_EN
      rX_address = 3'($urandom_range(0, 7));
      rY_address = 3'($urandom_range(0, 7));
`endif
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(6);

`ifdef WBQ_BYPASS_EN
    // Youngest-match bypass: two r5 entries, the younger must be forwarded
    $display("[TB] bypass");
    applyStimulus(1'b1, 3'd5, 16'h000A, 1'b1, 3'd5, 16'h000B);
    rX_address = 3'd5;
    rY_address = 3'd6;
    #1;
    checkOutput("byp_x_hit", fwd_x_hit, 1);
    checkOutput("byp_x", fwd_x, 16'h000B);
    checkOutput("byp_y_hit", fwd_y_hit, 0);
    checkOutput("byp_y", fwd_y, 0);
    idle(4);
`endif

    checkOutput("no_r0_writes", zero_writes, 0);
    checkOutput("max_count_le_depth", max_count <= DEPTH, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
